alu_exec_stage: RTL
===================

# alu_exec_stage

Execute/write-back stage that sits between the instruction source and the 16 x 16-bit register file. It accepts one command per handshake and reads two source registers through the file's A and B read ports. It computes one of eight ALU operations, where MUL is an iterative shift-add taking 16 cycles, and writes the result back through the file's single write port. The stage keeps a zero flag and a carry flag, and the stage itself removes any read-after-write hazard between consecutive commands.

## Interface
- DATA_W, 16, operand/result width
- ADDR_W, 4, register address width (16 registers)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  stage can accept; high only in IDLE
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
- cmd_rs1, cmd_rs2, cmd_rd  in  ADDR_W  source A, source B, destination register
- readAddrA, readAddrB  out  ADDR_W  to register-file read ports
- readDataA, readDataB  in  DATA_W  from register file (combinational read)
- writeEnable  out  1  register-file write strobe
- writeAddr  out  ADDR_W  write address
- writeData  out  DATA_W  write data
- done  out  1  one-cycle pulse, coincident with writeEnable
- zero, carry  out  1  flags of the last completed command

## Operation
- FSM states and transitions:
  - IDLE → READ on cmd_valid & cmd_ready; op, rs1, rs2 and rd are latched.
  - READ → EXEC. readAddrA/B are driven from the latched rs1/rs2. readDataA/B are latched as operands A/B at the end of READ.
  - EXEC → WB for non-MUL ops after 1 cycle. For MUL, EXEC lasts 16 cycles via a 4-bit iteration counter.
  - WB → IDLE.
- readAddrA/B hold the latched rs1/rs2 in all states.
- ADD: {carry, result} = A + B (17-bit sum).
- SUB: result = A − B mod 2^16; carry = 1 when A ≥ B (no borrow).
- AND, OR, XOR: bitwise on A and B.
- SHL / SHR: shift A by B[3:0]; B[15:4] is ignored; zero fill.
- MUL: low 16 bits of A×B. Each iteration adds the multiplicand when the multiplier LSB is 1, then shifts the multiplicand left and the multiplier right. Upper product bits are discarded.
- carry = 0 for all ops except ADD and SUB.
- WB cycle: writeEnable=1, writeAddr=rd, writeData=result, done=1. zero (result==0) and carry update at the edge ending WB and hold until the next WB.
- cmd_valid outside IDLE is ignored; there is no command queue.
- rd may equal rs1 or rs2. Operands are latched before the write, so the sources read their old values.

## Timing
- Reset (asynchronous; takes effect immediately):
  - State goes to IDLE.
  - cmd_ready=1.
  - writeEnable, done, zero and carry = 0.
  - writeAddr, writeData, readAddrA, readAddrB and all internal registers = 0.
- Acceptance edge = edge 0.
  - Non-MUL: READ is cycle 0–1, EXEC is cycle 1–2, and writeEnable is high in cycle 2–3. The register file captures the result at edge 3. cmd_ready is high again in cycle 3–4.
  - MUL: EXEC spans cycles 1–17, writeEnable is high in cycle 17–18, and the register file captures the result at edge 18.
- Throughput: one non-MUL command per 4 cycles, one MUL per 19 cycles.
- Hazards: the next command's READ is cycle ≥4–5, after the previous write at edge 3. Dependent back-to-back commands therefore see updated data and need no forwarding.
- Reset mid-operation (READ, EXEC or WB):
  - The command is aborted and no register is written.
  - If RST rises during WB, writeEnable drops asynchronously.
  - The next command after RST deasserts behaves normally.

## Test plan
The bench connects the stage to a behavioral 16 x 16 register-file model with backdoor preload.
- Reset: assert RST mid-idle → cmd_ready=1, writeEnable=0, done=0, zero=0, carry=0, readAddrA=readAddrB=0.
- ADD with carry: r1=0xFFFF, r2=0x0001, cmd ADD rd=r3 → writeEnable and done high only in cycle 2–3; r3=0x0000, zero=1, carry=1.
- SUB and SHR:
  - r4=0x0005, r5=0x0007, SUB rd=r6 → r6=0xFFFE, carry=0, zero=0.
  - Then r7=0x8000, r8=0x0013, SHR rd=r9 → r9=0x1000, carry=0.
- MUL: r10=0x0123, r11=0x0010, MUL rd=r12, with cmd_valid held high throughout → cmd_ready low cycles 0–18. The single write is in cycle 17–18, r12=0x1230, and no second command is accepted until cycle 18–19.
- Back-to-back dependency: r1=0x0003. Issue ADD rd=r1 (r1+r1), then immediately ADD rd=r2 (r1+r1) → r1=0x0006, r2=0x000C, second acceptance at edge 4.
- Reset during MUL: assert RST in cycle 8 of a MUL into r13 (r13 preloaded 0xAAAA) → writeEnable never asserts and r13 stays 0xAAAA. A following XOR r1^r2 with r1=0x0F0F, r2=0x00FF completes with result 0x0FF0.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute/write-back stage: reads two registers, runs one ALU op
// (iterative 16-step shift-add for MUL) and writes the result back.
module alu_exec_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [ADDR_W-1:0] cmd_rd,
   output logic [ADDR_W-1:0] readAddrA,
   output logic [ADDR_W-1:0] readAddrB,
   input  logic [DATA_W-1:0] readDataA,
   input  logic [DATA_W-1:0] readDataB,
   output logic              writeEnable,
   output logic [ADDR_W-1:0] writeAddr,
   output logic [DATA_W-1:0] writeData,
   output logic              done,
   output logic              zero,
   output logic              carry
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic [ADDR_W-1:0]   rs1_q, rs2_q, rd_q;
   logic [DATA_W-1:0]   a_q, b_q, res_q;
   logic [3:0]          cnt_q;
   logic                cpend_q, zero_q, carry_q;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic [DATA_W:0]     sum;

   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      unique case (op_q)
         OP_ADD: {alu_c, alu_res} = sum;
         OP_SUB: begin
            alu_res = a_q - b_q;
            alu_c   = (a_q >= b_q);
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_SHL: alu_res = a_q << b_q[3:0];
         OP_SHR: alu_res = a_q >> b_q[3:0];
         OP_MUL: alu_res = res_q;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cmd_valid) state_d = READ;
         READ: state_d = EXEC;
         EXEC: if (op_q != OP_MUL || cnt_q == 4'hF) state_d = WB;
         WB:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         op_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         cpend_q <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (cmd_valid) begin
               op_q  <= cmd_op;
               rs1_q <= cmd_rs1;
               rs2_q <= cmd_rs2;
               rd_q  <= cmd_rd;
            end
            READ: begin
               a_q     <= readDataA;
               b_q     <= readDataB;
               res_q   <= '0;
               cnt_q   <= '0;
               cpend_q <= 1'b0;
            end
            EXEC: if (op_q == OP_MUL) begin
               // a_q is the shifting multiplicand, b_q the multiplier
               if (b_q[0]) res_q <= res_q + a_q;
               a_q   <= a_q << 1;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + 4'd1;
            end else begin
               res_q   <= alu_res;
               cpend_q <= alu_c;
            end
            WB: begin
               zero_q  <= (res_q == '0);
               carry_q <= cpend_q;
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign writeEnable = (state_q == WB);
   assign done        = (state_q == WB);
   assign writeAddr   = rd_q;
   assign writeData   = res_q;
   assign readAddrA   = rs1_q;
   assign readAddrB   = rs2_q;
   assign zero        = zero_q;
   assign carry       = carry_q;

endmodule
